mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
Memory-access and write-back stage of the 8-bit pipelined processor. It consumes the EX-stage outputs of the ALU: result, store data, memory controls, destination register and flags.
- Performs loads and stores against an internal synchronous data memory.
- Produces the registered write-back bus for the register file.
- The same bus also feeds the forwarding path back into the ALU's data_in.

Parameters:
DATA_W, 8, datapath width
ADDR_W, 8, data-memory address width (memory depth = 2**ADDR_W)
RW_W, 5, destination-register index width
FLAG_W, 4, ALU flag width

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold stage; suppress memory write and register update
ans_ex  in  DATA_W  ALU result; memory address on loads and stores
B_Bypass  in  DATA_W  store data
flag_ex  in  FLAG_W  ALU flags
mem_en_ex  in  1  memory access this cycle
mem_rw_ex  in  1  1 = store, 0 = load (valid only when mem_en_ex=1)
mem_mux_sel_ex  in  1  1 = write back memory read data, 0 = write back ans_ex
RW_ex  in  RW_W  destination register index
wb_data  out  DATA_W  write-back / forwarding data
wb_rw  out  RW_W  write-back destination index
wb_en  out  1  register-file write enable
flag_wb  out  FLAG_W  flags, delayed one stage
store_cnt  out  8  number of committed stores; wraps 255->0

Behaviour:
- Reset is synchronous and active-high on clk rising edge. When reset=1 at an edge:
  - all stage registers clear, so wb_data=0, wb_rw=0, wb_en=0, flag_wb=0 and store_cnt=0.
  - any store presented that cycle is NOT committed.
  - RAM contents are not cleared.
- Latency: every input set appears on the wb_* outputs exactly 1 cycle later. There are no bubbles unless stall is asserted.
- Decode of the inputs present at a non-stalled edge:
  - store = mem_en_ex & mem_rw_ex.
  - load = mem_en_ex & ~mem_rw_ex.
- Store: at the edge, RAM[ans_ex] <= B_Bypass and store_cnt increments by 1 (modulo 256).
- Load: at the same edge, the RAM read register captures RAM[ans_ex].
- Stage registers captured at the same edge: ans_q, sel_q = mem_mux_sel_ex & load, wb_rw <= RW_ex, flag_wb <= flag_ex.
- Write-back mux: wb_data = sel_q ? ram_q : ans_q.
- If mem_mux_sel_ex=1 without a load (either mem_en_ex=0 or a store), the stage treats it as ALU write-back: wb_data = ans_q.
- wb_en <= (RW_ex != 0) & ~store. Register index 0 is never written.
- Load following a store to the same address in the next cycle returns the newly stored value; the RAM write completes before the next read. There is no same-cycle read/write, because each cycle carries a single operation.
- Stall=1 at an edge:
  - no RAM write; store_cnt holds.
  - ram_q, ans_q, sel_q, wb_rw, wb_en and flag_wb all hold, so the outputs are stable.
  - upstream keeps the inputs stable until stall drops; the held operation then executes on the first non-stalled edge.
- Reset has priority over stall.
- Address wrap: ans_ex uses all ADDR_W bits; no out-of-range case exists.
- All outputs are register-driven except the final wb_data 2:1 mux, which is fed only by registers.

Decomposition:
- Shared package cpu_pkg holds:
  - width constants DATA_W=8, ADDR_W=8, RW_W=5, FLAG_W=4.
  - the control-bit encodings MEM_RW_STORE=1 and MUX_SEL_MEM=1.
- One sub-module, data_mem_sync: single-port RAM, 2**ADDR_W x DATA_W.
  - inputs: clk, we, re, addr, wdata; output: rdata registered.
  - read-enable gated by stall.
- Pipeline registers, write-back mux and store counter live in mem_wb_stage.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with a store presented (ans_ex=8'h41, B_Bypass=8'hAA, mem_en_ex=1, mem_rw_ex=1) -> all outputs 0 and store_cnt=0. A later load from 8'h41 does not return 8'hAA.
2. ALU write-back: ans_ex=8'h00 (A=40 + B=C0), flag_ex=4'b0011, RW_ex=5, mem_en_ex=0 -> next cycle wb_data=8'h00, wb_rw=5, wb_en=1, flag_wb=4'b0011.
3. Store then load: cycle N stores with ans_ex=8'h41, B_Bypass=8'h08, RW_ex=10, mem_en_ex=1, mem_rw_ex=1 -> at N+1 wb_en=0 and store_cnt=1. Cycle N+1 loads with ans_ex=8'h41, mem_en_ex=1, mem_rw_ex=0, mem_mux_sel_ex=1, RW_ex=10 -> at N+2 wb_data=8'h08, wb_rw=10, wb_en=1.
4. Stall: assert stall for 3 cycles during a store to address 8'h20 with B_Bypass=8'h55 -> outputs frozen and store_cnt unchanged while stalled. The store commits on the first edge after stall drops, and store_cnt increments exactly once.
5. RW_ex=0 on an ALU op with ans_ex=8'h7F -> wb_en=0 and wb_data=8'h7F. Separately, mem_mux_sel_ex=1 with mem_en_ex=0 and ans_ex=8'h33 -> wb_data=8'h33.
6. Counter wrap: 256 consecutive stores -> store_cnt returns to 0. Back-to-back loads of 8'h00..8'hFF after writes return the written pattern with 1-cycle latency.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths and control-bit encodings for the 8-bit pipelined processor.
package cpu_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int RW_W   = 5;
  localparam int FLAG_W = 4;

  localparam logic MEM_RW_STORE = 1'b1;
  localparam logic MUX_SEL_MEM  = 1'b1;
endpackage

// File: rtl/data_mem_sync.sv
// Single-port synchronous data memory with a registered read port.
module data_mem_sync
  import cpu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Contents survive reset; the read register holds whenever re is low.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: load/store against data_mem_sync and the registered write-back bus.
module mem_wb_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] B_Bypass,
  input  logic [FLAG_W-1:0] flag_ex,
  input  logic              mem_en_ex,
  input  logic              mem_rw_ex,
  input  logic              mem_mux_sel_ex,
  input  logic [RW_W-1:0]   RW_ex,
  output logic [DATA_W-1:0] wb_data,
  output logic [RW_W-1:0]   wb_rw,
  output logic              wb_en,
  output logic [FLAG_W-1:0] flag_wb,
  output logic [7:0]        store_cnt
);

  logic              store_s;
  logic              load_s;
  logic              mem_we_s;
  logic              mem_re_s;
  logic [DATA_W-1:0] ram_q;

  logic [DATA_W-1:0] ans_q, ans_d;
  logic              sel_q, sel_d;
  logic [RW_W-1:0]   rw_q, rw_d;
  logic              en_q, en_d;
  logic [FLAG_W-1:0] flag_q, flag_d;
  logic [7:0]        cnt_q, cnt_d;

  assign store_s  = mem_en_ex & (mem_rw_ex == MEM_RW_STORE);
  assign load_s   = mem_en_ex & (mem_rw_ex != MEM_RW_STORE);
  // Reset must also block the RAM write, since the RAM itself has no reset.
  assign mem_we_s = store_s & ~stall & ~reset;
  assign mem_re_s = load_s & ~stall;

  data_mem_sync #(
    .DW (DATA_W),
    .AW (ADDR_W)
  ) u_dmem (
    .clk   (clk),
    .we    (mem_we_s),
    .re    (mem_re_s),
    .addr  (ans_ex[ADDR_W-1:0]),
    .wdata (B_Bypass),
    .rdata (ram_q)
  );

  // Next-state for the stage registers: hold on stall, otherwise capture EX outputs.
  always_comb begin
    ans_d  = ans_q;
    sel_d  = sel_q;
    rw_d   = rw_q;
    en_d   = en_q;
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (stall) begin
      ans_d  = ans_q;
      sel_d  = sel_q;
      rw_d   = rw_q;
      en_d   = en_q;
      flag_d = flag_q;
      cnt_d  = cnt_q;
    end else begin
      ans_d  = ans_ex;
      sel_d  = (mem_mux_sel_ex == MUX_SEL_MEM) & load_s;
      rw_d   = RW_ex;
      en_d   = (RW_ex != {RW_W{1'b0}}) & ~store_s;
      flag_d = flag_ex;
      cnt_d  = store_s ? (cnt_q + 8'd1) : cnt_q;
    end
  end

  // Stage registers with synchronous reset taking priority over stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      ans_q  <= {DATA_W{1'b0}};
      sel_q  <= 1'b0;
      rw_q   <= {RW_W{1'b0}};
      en_q   <= 1'b0;
      flag_q <= {FLAG_W{1'b0}};
      cnt_q  <= 8'd0;
    end else begin
      ans_q  <= ans_d;
      sel_q  <= sel_d;
      rw_q   <= rw_d;
      en_q   <= en_d;
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wb_data   = sel_q ? ram_q : ans_q;
  assign wb_rw     = rw_q;
  assign wb_en     = en_q;
  assign flag_wb   = flag_q;
  assign store_cnt = cnt_q;

endmodule
